sid_voice_mixer_dac: RTL and testbench
======================================

// Module: sid_voice_mixer_dac
// PURPOSE
//  Output stage downstream of both SID voices: sums the two 8-bit voice samples,
//  applies a zipper-free ramped master volume and drives a 1-bit audio pin.
//  Default modulator is a PWM comparator; sigma-delta is a build option.
//  Sits between voice outputs and the top-level pin driving the RC filter.
// PARAMETERS
//  PWM_BITS      8  PWM counter / duty width (>=8); mix is left-aligned into it
//  RAMP_PERIODS  1  PWM periods per +/-1 step of the volume ramp (1..255)
// PORTS
//  clk            in   1         system clock
//  rst_n          in   1         asynchronous, active-low reset
//  voice1         in   8         voice 1 sample (unsigned)
//  voice2         in   8         voice 2 sample (unsigned)
//  volume         in   4         target master volume, 0..15
//  mute           in   1         1 = ramp volume to 0; target restored on release
//  audio_out      out  1         1-bit DAC output
//  sample_strobe  out  1         1-cycle pulse when new duty takes effect
//  duty           out  PWM_BITS  duty currently applied (debug/verification)
//  vol_cur        out  4         current (ramped) volume
// BEHAVIOUR
//  Reset (async assert, sync release): all regs 0; audio_out=0, sample_strobe=0,
//   duty=0, vol_cur=0, pwm_cnt=0, ramp counter=0.
//  pwm_cnt free-runs 0..2^PWM_BITS-1, wraps to 0; "wrap" = cycle pwm_cnt==MAX.
//  Pipeline, every cycle: S1 sum9 <= voice1+voice2 (0..510);
//   S2 mix8 <= (sum9*vol_cur)>>5 (max 510*15>>5 = 239, fits 8 bits, no sat).
//  On wrap: duty <= mix8 << (PWM_BITS-8); sample_strobe=1 in the cycle that
//   pwm_cnt==0 (same edge duty updates). Voice->duty latency: 2 cycles + wait
//   for next wrap; mid-period voice changes never alter current period.
//  PWM: audio_out registered = (pwm_cnt < duty). duty=0 -> constant 0;
//   duty=MAX -> high MAX of 2^PWM_BITS cycles. Output lags compare by 1 cycle.
//  Volume ramp: target = mute ? 0 : volume. Ramp counter counts wraps; after
//   RAMP_PERIODS wraps, vol_cur moves 1 toward target (never overshoots), counter
//   clears. vol_cur==target -> hold, counter held at 0. Target change mid-ramp:
//   next step heads to new target, counter not cleared. vol_cur updates only on
//   wrap, so S2 uses a constant volume within a period.
//  Simultaneous mute and volume change: mute wins (target 0).
//  rst_n asserted mid-period: output drops to 0 immediately (async);
//   after release first period outputs duty 0.
// CONFIGURATION
//  SID_MIX_SIGMA_DELTA_EN defined: comparator replaced by 1st-order sigma-delta:
//   acc[PWM_BITS:0] <= acc[PWM_BITS-1:0] + duty each cycle; audio_out =
//   registered acc[PWM_BITS] (carry). acc reset 0. Density over 2^PWM_BITS
//   cycles equals duty exactly. pwm_cnt still runs for wrap/strobe/ramp timing.
//  Undefined: PWM comparator as above. Ports identical in both builds.
// STRUCTURE
//  Shared include sid_pkg.vh: SID_VOICE_W=8, SID_VOL_W=4, SID_MIX_SHIFT=5 and
//   SID_MIX_MAX=239 constants, used by voices and this block.
//  One sub-module: sid_dac_mod (pwm_cnt, wrap detect, duty register,
//   comparator or sigma-delta accumulator). Top keeps adder/scale pipeline
//   and volume ramp.
// TESTING
//  1 Reset, volume=15 mute=0 voices=0: vol_cur 0->15 in 15 wraps
//    (RAMP_PERIODS=1); audio_out stays 0.
//  2 vol_cur=15, voice1=voice2=255: duty=239 after next wrap; audio_out high
//    exactly 239 of 256 cycles per period; strobe once per 256 cycles.
//  3 vol_cur=8, voice1=100 voice2=60: duty=(160*8)>>5=40; voice change mid-period
//    leaves current period's high count at 40.
//  4 mute=1 at vol_cur=15: vol_cur steps 14..0 one per wrap; duty reaches 0,
//    output constant 0; mute=0 ramps back to volume.
//  5 RAMP_PERIODS=4, volume 3->10: vol_cur increments every 4th wrap; change
//    target to 5 mid-ramp: stops at 5 without overshoot.
//  6 rst_n low mid-period with duty=200: audio_out, duty, vol_cur 0 same cycle;
//    with SID_MIX_SIGMA_DELTA_EN, duty=64 -> exactly 64 ones per 256 cycles.

Source files
------------

// File: rtl/sid_voice_mixer_dac_pkg.sv
// Shared constants and volume-ramp helpers for the SID voice mixer and its DAC modulator.
package sid_voice_mixer_dac_pkg;

    localparam int SID_VOICE_W   = 8;
    localparam int SID_VOL_W     = 4;
    localparam int SID_MIX_SHIFT = 5;
    localparam int SID_MIX_MAX   = 239;

    localparam int SID_SUM_W  = SID_VOICE_W + 1;
    localparam int SID_PROD_W = SID_SUM_W + SID_VOL_W;
    localparam int SID_MIX_W  = $clog2(SID_MIX_MAX + 1);

    typedef enum logic [1:0] {
        RAMP_HOLD,
        RAMP_UP,
        RAMP_DOWN
    } ramp_dir_t;

    function automatic ramp_dir_t ramp_dir(input logic [SID_VOL_W-1:0] cur,
                                           input logic [SID_VOL_W-1:0] target);
        if (cur < target) return RAMP_UP;
        if (cur > target) return RAMP_DOWN;
        return RAMP_HOLD;
    endfunction

endpackage

// File: rtl/sid_voice_mixer_dac_dac_mod.sv
// 1-bit DAC modulator: free-running period counter, wrap-latched duty, PWM comparator
// or (with SID_MIX_SIGMA_DELTA_EN defined) a first-order sigma-delta accumulator.
module sid_dac_mod
    import sid_voice_mixer_dac_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SID_MIX_W-1:0] mix,
    output logic                 wrap,
    output logic                 audio_out,
    output logic                 sample_strobe,
    output logic [PWM_BITS-1:0]  duty
);

    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

    logic [PWM_BITS-1:0] cnt_reg;
    logic [PWM_BITS-1:0] duty_reg;
    logic [PWM_BITS-1:0] aligned;
    logic                strobe_reg;

    // Mix is left-aligned so its full scale tracks the period length.
    assign aligned = PWM_BITS'(mix) << (PWM_BITS - SID_MIX_W);
    assign wrap    = (cnt_reg == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            duty_reg   <= '0;
            strobe_reg <= 1'b0;
        end else begin
            cnt_reg    <= cnt_reg + 1'b1;
            strobe_reg <= wrap;
            if (wrap) begin
                duty_reg <= aligned;
            end
        end
    end

`ifdef SID_MIX_SIGMA_DELTA_EN
    logic [PWM_BITS:0] acc_reg;

    // Carry out of the phase accumulator is the output bit; density is duty/2^PWM_BITS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
        end else begin
            acc_reg <= {1'b0, acc_reg[PWM_BITS-1:0]} + {1'b0, duty_reg};
        end
    end

    assign audio_out = acc_reg[PWM_BITS];
`else
    logic out_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg <= 1'b0;
        end else begin
            out_reg <= (cnt_reg < duty_reg);
        end
    end

    assign audio_out = out_reg;
`endif

    assign sample_strobe = strobe_reg;
    assign duty          = duty_reg;

endmodule

// File: rtl/sid_voice_mixer_dac.sv
// Two-voice mixer with ramped master volume feeding a 1-bit DAC (sid_dac_mod).
// Define SID_MIX_SIGMA_DELTA_EN to use the sigma-delta modulator instead of PWM.
module sid_voice_mixer_dac
    import sid_voice_mixer_dac_pkg::*;
#(
    parameter int PWM_BITS     = 8,
    parameter int RAMP_PERIODS = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [SID_VOICE_W-1:0] voice1,
    input  logic [SID_VOICE_W-1:0] voice2,
    input  logic [SID_VOL_W-1:0]   volume,
    input  logic                   mute,
    output logic                   audio_out,
    output logic                   sample_strobe,
    output logic [PWM_BITS-1:0]    duty,
    output logic [SID_VOL_W-1:0]   vol_cur
);

    localparam logic [7:0] RAMP_LAST = 8'(RAMP_PERIODS - 1);

    logic [SID_SUM_W-1:0]  sum_reg;
    logic [SID_MIX_W-1:0]  mix_reg;
    logic [SID_PROD_W-1:0] prod;
    logic [SID_VOL_W-1:0]  vol_reg;
    logic [SID_VOL_W-1:0]  vol_next;
    logic [SID_VOL_W-1:0]  target;
    logic [7:0]            ramp_cnt_reg;
    logic [7:0]            ramp_cnt_next;
    ramp_dir_t             dir;
    logic                  wrap;

    assign prod = SID_PROD_W'(sum_reg) * SID_PROD_W'(vol_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg <= '0;
            mix_reg <= '0;
        end else begin
            sum_reg <= SID_SUM_W'(voice1) + SID_SUM_W'(voice2);
            mix_reg <= prod[SID_PROD_W-1:SID_MIX_SHIFT];
        end
    end

    // Mute overrides the requested volume; the ramp walks toward whichever applies.
    assign target = mute ? '0 : volume;
    assign dir    = ramp_dir(vol_reg, target);

    always_comb begin
        vol_next      = vol_reg;
        ramp_cnt_next = ramp_cnt_reg;
        if (wrap) begin
            if (dir == RAMP_HOLD) begin
                ramp_cnt_next = '0;
            end else if (ramp_cnt_reg == RAMP_LAST) begin
                ramp_cnt_next = '0;
                vol_next      = (dir == RAMP_UP) ? vol_reg + 1'b1 : vol_reg - 1'b1;
            end else begin
                ramp_cnt_next = ramp_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vol_reg      <= '0;
            ramp_cnt_reg <= '0;
        end else begin
            vol_reg      <= vol_next;
            ramp_cnt_reg <= ramp_cnt_next;
        end
    end

    sid_dac_mod #(
        .PWM_BITS(PWM_BITS)
    ) u_dac_mod (
        .clk          (clk),
        .rst_n        (rst_n),
        .mix          (mix_reg),
        .wrap         (wrap),
        .audio_out    (audio_out),
        .sample_strobe(sample_strobe),
        .duty         (duty)
    );

    assign vol_cur = vol_reg;

endmodule

// File: tb/tb_sid_voice_mixer_dac.sv
// Directed + randomized bench for sid_voice_mixer_dac: one instance with a 1-period ramp
// and one with a 4-period ramp, both checked against a per-period arithmetic model.
module tb_sid_voice_mixer_dac;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] v1, v2;
    logic [3:0] vol_in [2];
    logic       mute_in [2];

    logic       audio0, audio1, strobe0, strobe1;
    logic [7:0] duty0, duty1;
    logic [3:0] vcur0, vcur1;

    int checks   = 0;
    int failures = 0;
    int ph;
    int vol_m  [2];
    int rc_m   [2];
    int duty_m [2];
    int hi     [2];
    int rp     [2] = '{1, 4};

    always #5 clk = ~clk;

    sid_voice_mixer_dac #(.PWM_BITS(8), .RAMP_PERIODS(1)) dut (
        .clk(clk), .rst_n(rst_n), .voice1(v1), .voice2(v2),
        .volume(vol_in[0]), .mute(mute_in[0]),
        .audio_out(audio0), .sample_strobe(strobe0), .duty(duty0), .vol_cur(vcur0)
    );

    sid_voice_mixer_dac #(.PWM_BITS(8), .RAMP_PERIODS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .voice1(v1), .voice2(v2),
        .volume(vol_in[1]), .mute(mute_in[1]),
        .audio_out(audio1), .sample_strobe(strobe1), .duty(duty1), .vol_cur(vcur1)
    );

    task automatic check(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, i, obs, exp);
        end
    endtask

    task automatic model_reset();
        ph = 0;
        for (int i = 0; i < 2; i++) begin
            vol_m[i] = 0; rc_m[i] = 0; duty_m[i] = 0; hi[i] = 0;
        end
    endtask

    // One clock: observe after the edge, apply the per-period rules whenever a wrap just occurred.
    task automatic tick();
        logic       a [2];
        logic       s [2];
        logic [7:0] d [2];
        logic [3:0] vc [2];
        int         tgt;
        @(negedge clk);
        ph = (ph + 1) % 256;
        a[0] = audio0;  a[1] = audio1;
        s[0] = strobe0; s[1] = strobe1;
        d[0] = duty0;   d[1] = duty1;
        vc[0] = vcur0;  vc[1] = vcur1;
        for (int i = 0; i < 2; i++) begin
            if (ph == 0) begin
                hi[i] += int'(a[i]);
                check("high_count", i, hi[i], duty_m[i]);
                hi[i] = 0;
                check("strobe_on_wrap", i, s[i], 1);
                duty_m[i] = ((int'(v1) + int'(v2)) * vol_m[i]) / 32;
                tgt = mute_in[i] ? 0 : int'(vol_in[i]);
                if (vol_m[i] == tgt) begin
                    rc_m[i] = 0;
                end else if (rc_m[i] + 1 >= rp[i]) begin
                    vol_m[i] += (tgt > vol_m[i]) ? 1 : -1;
                    rc_m[i] = 0;
                end else begin
                    rc_m[i]++;
                end
                check("duty", i, d[i], duty_m[i]);
                check("vol_cur", i, vc[i], vol_m[i]);
            end else begin
                check("strobe_idle", i, s[i], 0);
                hi[i] += int'(a[i]);
            end
        end
    endtask

    // mode 0: steady inputs; 1: random voices mid-period; 2: random voices, volume and mute.
    task automatic run_periods(input int n, input int mode);
        for (int p = 0; p < n; p++) begin
            for (int c = 0; c < 256; c++) begin
                tick();
                if (ph == 128 && mode > 0) begin
                    v1 = 8'($urandom_range(0, 255));
                    v2 = 8'($urandom_range(0, 255));
                    if (mode == 2) begin
                        for (int i = 0; i < 2; i++) begin
                            vol_in[i]  = 4'($urandom_range(0, 15));
                            mute_in[i] = ($urandom_range(0, 3) == 0);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        v1 = 8'd0; v2 = 8'd0;
        vol_in[0] = 4'd15; vol_in[1] = 4'd3;
        mute_in[0] = 1'b0; mute_in[1] = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_audio", 0, audio0, 0);
        check("reset_strobe", 0, strobe0, 0);
        check("reset_duty", 0, duty0, 0);
        check("reset_vol", 0, vcur0, 0);
        check("reset_audio", 1, audio1, 0);
        check("reset_vol", 1, vcur1, 0);
        rst_n = 1'b1;

        // Ramp-up from reset with silent voices.
        run_periods(16, 0);
        check("ramp_up_done", 0, vcur0, 15);
        check("slow_ramp_at_3", 1, vcur1, 3);

        // Full-scale voices at full volume; slow instance heads to 10.
        vol_in[1] = 4'd10;
        v1 = 8'd255; v2 = 8'd255;
        run_periods(3, 0);
        check("duty_full_scale", 0, duty0, 239);

        // Volume 8 with 100+60, then mid-period voice changes; slow target cut to 5 mid-ramp.
        vol_in[1] = 4'd5;
        vol_in[0] = 4'd8;
        run_periods(8, 0);
        v1 = 8'd100; v2 = 8'd60;
        run_periods(2, 0);
        check("duty_160x8", 0, duty0, 40);
        run_periods(4, 1);
        check("slow_ramp_stop_5", 1, vcur1, 5);

        // Mute ramps to zero, release ramps back.
        vol_in[0] = 4'd15;
        v1 = 8'd255; v2 = 8'd255;
        run_periods(8, 0);
        mute_in[0] = 1'b1;
        run_periods(17, 0);
        check("muted_vol", 0, vcur0, 0);
        check("muted_duty", 0, duty0, 0);
        mute_in[0] = 1'b0;
        run_periods(17, 0);
        check("unmuted_vol", 0, vcur0, 15);

        // Reset asserted mid-period with duty 200.
        v1 = 8'd214; v2 = 8'd213;
        run_periods(2, 0);
        while (ph != 100) tick();
        check("pre_reset_duty", 0, duty0, 200);
        check("pre_reset_audio", 0, audio0, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_audio", 0, audio0, 0);
        check("async_reset_duty", 0, duty0, 0);
        check("async_reset_vol", 0, vcur0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run_periods(3, 0);

        // Randomized tail.
        run_periods(20, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
